// File: rtl/recorder_pkg.sv
// Shared types and constants for the recording writer.
//   WORD_W      : BRAM word width (64 bits)
//   ADDR_W_DEF  : default BRAM word-address width
//   BUF_W_DEF   : default buffer-index width
//   state_t     : writer FSM states
//   mode_t      : sample packing mode
package recorder_pkg;
   localparam int WORD_W     = 64;
   localparam int ADDR_W_DEF = 12;
   localparam int BUF_W_DEF  = 6;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } state_t;

   typedef enum logic {
      MODE_16 = 1'b0,
      MODE_8  = 1'b1
   } mode_t;
endpackage

// File: rtl/sample_packer.sv
// Packs complex IQ samples into 64-bit words.
// Optional feature macro: RECORDER_8BIT_EN (adds 4-sample 8-bit packing).
// Ports:
//   clk, rst           clock, asynchronous active-low reset
//   clear              drop any partially assembled word
//   in_valid           sample strobe (already qualified by the writer FSM)
//   in_re, in_im       signed sample components
//   mode8              1 = 8-bit packing (only with RECORDER_8BIT_EN)
//   word_vld, word     a complete word is presented this cycle
//   pad_word           partially assembled word, upper lanes zero
//   partial            at least one sample is held in pad_word
module sample_packer
   import recorder_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                clear,
   input  logic                in_valid,
   input  logic signed [15:0]  in_re,
   input  logic signed [15:0]  in_im,
`ifdef RECORDER_8BIT_EN
   input  logic                mode8,
`endif
   output logic                word_vld,
   output logic [WORD_W-1:0]   word,
   output logic [WORD_W-1:0]   pad_word,
   output logic                partial
);

   logic [1:0]        lane;
   logic [1:0]        last_lane;
   logic [WORD_W-1:0] acc;
   logic [WORD_W-1:0] ins;

   // Lanes above the current one are always zero in acc, so OR-ing the new
   // sample in assembles the word and the same register doubles as padding.
   always_comb begin
      last_lane = 2'd1;
      ins       = {32'b0, in_im, in_re} << {lane[0], 5'b0};
`ifdef RECORDER_8BIT_EN
      if (mode8) begin
         last_lane = 2'd3;
         ins       = {48'b0, in_im[15:8], in_re[15:8]} << {lane, 4'b0};
      end
`endif
   end

   assign word     = acc | ins;
   assign word_vld = in_valid && (lane == last_lane);
   assign pad_word = acc;
   assign partial  = (lane != 2'd0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lane <= 2'd0;
         acc  <= '0;
      end else if (clear) begin
         lane <= 2'd0;
         acc  <= '0;
      end else if (in_valid) begin
         if (lane == last_lane) begin
            lane <= 2'd0;
            acc  <= '0;
         end else begin
            lane <= lane + 2'd1;
            acc  <= word;
         end
      end
   end

endmodule

// File: rtl/recorder_writer.sv
// Recording writer: packs IQ samples into 64-bit words and writes them into a
// ring of equal-size BRAM buffers, announcing each completed buffer and
// refusing to overwrite buffers not yet freed by the DMA stage.
// Optional feature macro: RECORDER_8BIT_EN (8-bit packing selected by mode).
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   start, stop              arm recording at word 0 / end with a flush
//   mode                     0 = 16-bit, 1 = 8-bit samples (latched on start)
//   in_valid, in_re, in_im   sample stream, no backpressure
//   rd_buffer                oldest buffer not yet freed by the DMA
//   waddr, wdata, wren       BRAM write port (registered)
//   buffer_done, buffer_idx,
//   buffer_words             completed-buffer announcement
//   busy, overflow           status; overflow is sticky until start
module recorder_writer
   import recorder_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int BUF_W  = BUF_W_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  mode,
   input  logic                  in_valid,
   input  logic signed [15:0]    in_re,
   input  logic signed [15:0]    in_im,
   input  logic [BUF_W-1:0]      rd_buffer,
   output logic [ADDR_W-1:0]     waddr,
   output logic [WORD_W-1:0]     wdata,
   output logic                  wren,
   output logic                  buffer_done,
   output logic [BUF_W-1:0]      buffer_idx,
   output logic [ADDR_W-BUF_W:0] buffer_words,
   output logic                  busy,
   output logic                  overflow
);

   localparam int OFF_W = ADDR_W - BUF_W;
   localparam logic [OFF_W:0]    CNT_ONE  = {{OFF_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] ptr;
   logic              any_done;
   logic              fl2;
   logic              close_q;

   logic              smp_vld;
   logic              pk_clear;
   logic              pk_vld;
   logic              pk_partial;
   logic [WORD_W-1:0] pk_word;
   logic [WORD_W-1:0] pk_pad;

   logic              wr_req;
   logic [WORD_W-1:0] wr_word;
   logic              wr_close;
   logic              full_hit;
   logic              flush_empty_done;

`ifdef RECORDER_8BIT_EN
   mode_t mode_q;
`else
   logic  unused_mode;
   assign unused_mode = mode;
`endif

   assign smp_vld  = in_valid && (state == RUN) && !start;
   // FLUSH consumes whatever partial word exists, so the packer is emptied.
   assign pk_clear = start || (state == FLUSH);

   sample_packer u_packer (
      .clk      (clk),
      .rst      (rst),
      .clear    (pk_clear),
      .in_valid (smp_vld),
      .in_re    (in_re),
      .in_im    (in_im),
`ifdef RECORDER_8BIT_EN
      .mode8    (mode_q == MODE_8),
`endif
      .word_vld (pk_vld),
      .word     (pk_word),
      .pad_word (pk_pad),
      .partial  (pk_partial)
   );

   // A write closes its buffer when it lands on the last offset, or when it is
   // the padded word written by FLUSH.
   always_comb begin
      wr_req  = 1'b0;
      wr_word = pk_word;
      if (!start) begin
         if (state == RUN && pk_vld) begin
            wr_req = 1'b1;
         end else if (state == FLUSH && !fl2 && pk_partial) begin
            wr_req  = 1'b1;
            wr_word = pk_pad;
         end
      end
   end

   assign wr_close = (ptr[OFF_W-1:0] == {OFF_W{1'b1}}) || (state == FLUSH);
   assign full_hit = wr_req && (ptr[OFF_W-1:0] == '0) &&
                     (ptr[ADDR_W-1 -: BUF_W] == rd_buffer) && any_done;
   // Flush with no partial word but a partly filled buffer: announce it directly.
   assign flush_empty_done = (state == FLUSH) && !fl2 && !pk_partial &&
                             (ptr[OFF_W-1:0] != '0) && !start;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (start) state_nxt = RUN;
         RUN: begin
            if (start)         state_nxt = RUN;
            else if (full_hit) state_nxt = IDLE;
            else if (stop)     state_nxt = FLUSH;
         end
         FLUSH: begin
            if (start)                  state_nxt = RUN;
            else if (full_hit)          state_nxt = IDLE;
            else if (!fl2 && pk_partial) state_nxt = FLUSH;
            else                        state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         ptr          <= '0;
         any_done     <= 1'b0;
         fl2          <= 1'b0;
         close_q      <= 1'b0;
         waddr        <= '0;
         wdata        <= '0;
         wren         <= 1'b0;
         buffer_done  <= 1'b0;
         buffer_idx   <= '0;
         buffer_words <= '0;
         overflow     <= 1'b0;
`ifdef RECORDER_8BIT_EN
         mode_q       <= MODE_16;
`endif
      end else begin
         state       <= state_nxt;
         fl2         <= (state == FLUSH) && (state_nxt == FLUSH);
         wren        <= 1'b0;
         close_q     <= 1'b0;
         buffer_done <= 1'b0;

         if (start) begin
            ptr      <= '0;
            any_done <= 1'b0;
            overflow <= 1'b0;
`ifdef RECORDER_8BIT_EN
            mode_q   <= mode_t'(mode);
`endif
         end else if (wr_req) begin
            if (full_hit) begin
               overflow <= 1'b1;
            end else begin
               wren    <= 1'b1;
               waddr   <= ptr;
               wdata   <= wr_word;
               close_q <= wr_close;
               ptr     <= ptr + ADDR_ONE;
               if (wr_close) any_done <= 1'b1;
            end
         end

         // Announce one cycle after the closing write so the data is in BRAM.
         if (!start && wren && close_q) begin
            buffer_done  <= 1'b1;
            buffer_idx   <= waddr[ADDR_W-1 -: BUF_W];
            buffer_words <= {1'b0, waddr[OFF_W-1:0]} + CNT_ONE;
         end else if (flush_empty_done) begin
            buffer_done  <= 1'b1;
            buffer_idx   <= ptr[ADDR_W-1 -: BUF_W];
            buffer_words <= {1'b0, ptr[OFF_W-1:0]};
         end
      end
   end

endmodule

// File: tb/tb_recorder_writer.sv
// Self-checking bench for recorder_writer: random and patterned sample
// streams compared against a word/buffer-level reference model.
module tb_recorder_writer;

`ifdef RECORDER_8BIT_EN
   localparam bit HAS8 = 1'b1;
`else
   localparam bit HAS8 = 1'b0;
`endif

   logic               clk;
   logic               rst;
   logic               start;
   logic               stop;
   logic               mode;
   logic               in_valid;
   logic signed [15:0] in_re;
   logic signed [15:0] in_im;
   logic [5:0]         rd_buffer;
   logic [11:0]        waddr;
   logic [63:0]        wdata;
   logic               wren;
   logic               buffer_done;
   logic [5:0]         buffer_idx;
   logic [6:0]         buffer_words;
   logic               busy;
   logic               overflow;

   int n_checks = 0;
   int n_fail   = 0;

   // observed traffic
   logic [11:0] wa_q[$];
   logic [63:0] wd_q[$];
   logic [5:0]  di_q[$];
   logic [6:0]  dw_q[$];
   // expected traffic
   logic [11:0] ea_q[$];
   logic [63:0] ed_q[$];
   logic [5:0]  ei_q[$];
   logic [6:0]  ew_q[$];
   // stimulus samples
   logic [15:0] smp_re[$];
   logic [15:0] smp_im[$];
   // DMA freeing emulation
   bit          free_en = 1'b0;
   logic [5:0]  rd_set  = '0;
   int          fr_t[$];
   logic [5:0]  fr_v[$];
   int          cyc_cnt = 0;

   recorder_writer dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .stop         (stop),
      .mode         (mode),
      .in_valid     (in_valid),
      .in_re        (in_re),
      .in_im        (in_im),
      .rd_buffer    (rd_buffer),
      .waddr        (waddr),
      .wdata        (wdata),
      .wren         (wren),
      .buffer_done  (buffer_done),
      .buffer_idx   (buffer_idx),
      .buffer_words (buffer_words),
      .busy         (busy),
      .overflow     (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor and DMA model, away from the active edge.
   always @(negedge clk) begin
      cyc_cnt++;
      if (wren) begin
         wa_q.push_back(waddr);
         wd_q.push_back(wdata);
      end
      if (buffer_done) begin
         di_q.push_back(buffer_idx);
         dw_q.push_back(buffer_words);
         if (free_en) begin
            fr_t.push_back(cyc_cnt + 10);
            fr_v.push_back(6'(buffer_idx + 6'd1));
         end
      end
      if (!free_en) rd_buffer = rd_set;
      else if (fr_t.size() > 0 && fr_t[0] <= cyc_cnt) begin
         rd_buffer = fr_v.pop_front();
         void'(fr_t.pop_front());
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic pulse_stop();
      stop = 1'b1;
      tick();
      stop = 1'b0;
   endtask

   task automatic clear_obs();
      wa_q.delete(); wd_q.delete(); di_q.delete(); dw_q.delete();
   endtask

   task automatic finish_run();
      repeat (4) tick();
      pulse_stop();
      repeat (6) tick();
   endtask

   task automatic stream(input int gap_pct);
      for (int i = 0; i < smp_re.size(); i++) begin
         while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
            in_valid = 1'b0;
            in_re    = 16'($urandom);
            tick();
         end
         in_valid = 1'b1;
         in_re    = smp_re[i];
         in_im    = smp_im[i];
         tick();
      end
      in_valid = 1'b0;
   endtask

   // Reference model: word k holds samples k*spw .. k*spw+spw-1, lane s of the
   // word at bit 32*s (16-bit) or 16*s (8-bit); missing samples are zero.
   // Words land at k mod 4096; a buffer completes every 64 words and a final
   // partly filled buffer is announced by the flush. At most `limit` words.
   task automatic build_expect(input bit m8, input int limit);
      int spw, n, nw, nk;
      logic [63:0] w;
      ea_q.delete(); ed_q.delete(); ei_q.delete(); ew_q.delete();
      spw = (m8 && HAS8) ? 4 : 2;
      n   = smp_re.size();
      nw  = (n + spw - 1) / spw;
      nk  = (nw > limit) ? limit : nw;
      for (int k = 0; k < nk; k++) begin
         w = '0;
         for (int s = 0; s < spw; s++) begin
            if (k * spw + s < n) begin
               if (spw == 4) w[16*s +: 16] = {smp_im[k*spw+s][15:8], smp_re[k*spw+s][15:8]};
               else          w[32*s +: 32] = {smp_im[k*spw+s], smp_re[k*spw+s]};
            end
         end
         ea_q.push_back(12'(k % 4096));
         ed_q.push_back(w);
         if (k % 64 == 63) begin
            ei_q.push_back(6'((k / 64) % 64));
            ew_q.push_back(7'd64);
         end
      end
      if (nk == nw && nw % 64 != 0) begin
         ei_q.push_back(6'((nw / 64) % 64));
         ew_q.push_back(7'(nw % 64));
      end
   endtask

   function automatic int diff_writes();
      for (int i = 0; i < wa_q.size() && i < ea_q.size(); i++)
         if (wa_q[i] !== ea_q[i] || wd_q[i] !== ed_q[i]) return i;
      return -1;
   endfunction

   function automatic int diff_dones();
      for (int i = 0; i < di_q.size() && i < ei_q.size(); i++)
         if (di_q[i] !== ei_q[i] || dw_q[i] !== ew_q[i]) return i;
      return -1;
   endfunction

   task automatic test_reset();
      n_checks++;
      if ({wren, buffer_done, busy, overflow} !== 4'b0) begin
         n_fail++;
         $display("FAIL reset_flags: got %b want 0000", {wren, buffer_done, busy, overflow});
      end
      n_checks++;
      if (waddr !== 12'd0 || wdata !== 64'd0) begin
         n_fail++;
         $display("FAIL reset_wport: got %h/%h want 0/0", waddr, wdata);
      end
      n_checks++;
      if (buffer_idx !== 6'd0 || buffer_words !== 7'd0) begin
         n_fail++;
         $display("FAIL reset_done_info: got %0d/%0d want 0/0", buffer_idx, buffer_words);
      end
   endtask

   task automatic test_16bit_ramp();
      int d;
      logic [63:0] w0;
      smp_re.delete(); smp_im.delete();
      for (int n = 0; n < 128; n++) begin
         smp_re.push_back(16'(n));
         smp_im.push_back(16'(-n));
      end
      rd_set = '0; mode = 1'b0;
      clear_obs(); pulse_start(); stream(0); finish_run();
      build_expect(1'b0, 1 << 30);
      n_checks++;
      if (wa_q.size() != 64) begin
         n_fail++; $display("FAIL ramp16_wcount: got %0d want 64", wa_q.size());
      end
      d = diff_writes(); n_checks++;
      if (d != -1) begin
         n_fail++;
         $display("FAIL ramp16_data: word %0d got %h@%h want %h@%h", d, wd_q[d], wa_q[d], ed_q[d], ea_q[d]);
      end
      w0 = (wd_q.size() > 0) ? wd_q[0] : 'x;
      n_checks++;
      if (w0 !== 64'hFFFF_0001_0000_0000) begin
         n_fail++; $display("FAIL ramp16_word0: got %h want ffff000100000000", w0);
      end
      n_checks++;
      if (di_q.size() != 1 || di_q[0] !== 6'd0 || dw_q[0] !== 7'd64) begin
         n_fail++;
         $display("FAIL ramp16_done: got n=%0d idx=%0d words=%0d want n=1 idx=0 words=64", di_q.size(), di_q[0], dw_q[0]);
      end
   endtask

   task automatic test_16bit_random();
      int d;
      smp_re.delete(); smp_im.delete();
      for (int n = 0; n < 151; n++) begin
         smp_re.push_back(16'($urandom));
         smp_im.push_back(16'($urandom));
      end
      rd_set = '0; mode = 1'b0;
      clear_obs(); pulse_start(); stream(30); finish_run();
      build_expect(1'b0, 1 << 30);
      n_checks++;
      if (wa_q.size() != ea_q.size()) begin
         n_fail++; $display("FAIL rand16_wcount: got %0d want %0d", wa_q.size(), ea_q.size());
      end
      d = diff_writes(); n_checks++;
      if (d != -1) begin
         n_fail++;
         $display("FAIL rand16_data: word %0d got %h@%h want %h@%h", d, wd_q[d], wa_q[d], ed_q[d], ea_q[d]);
      end
      n_checks++;
      if (di_q.size() != ei_q.size() || diff_dones() != -1) begin
         n_fail++;
         $display("FAIL rand16_done: got n=%0d last=%0d/%0d want n=%0d last=%0d/%0d",
                  di_q.size(), di_q[$], dw_q[$], ei_q.size(), ei_q[$], ew_q[$]);
      end
   endtask

   task automatic test_8bit();
      int d;
      smp_re.delete(); smp_im.delete();
      for (int n = 0; n < 256; n++) begin
         smp_re.push_back(16'(n << 8));
         smp_im.push_back(16'($urandom));
      end
      rd_set = '0; mode = 1'b1;
      clear_obs(); pulse_start(); mode = 1'b0; stream(0); finish_run();
      build_expect(1'b1, 1 << 30);
      n_checks++;
      if (wa_q.size() != ea_q.size()) begin
         n_fail++; $display("FAIL mode8_wcount: got %0d want %0d", wa_q.size(), ea_q.size());
      end
      d = diff_writes(); n_checks++;
      if (d != -1) begin
         n_fail++;
         $display("FAIL mode8_data: word %0d got %h@%h want %h@%h", d, wd_q[d], wa_q[d], ed_q[d], ea_q[d]);
      end
      n_checks++;
      if (di_q.size() != ei_q.size() || diff_dones() != -1) begin
         n_fail++; $display("FAIL mode8_done: got n=%0d want n=%0d", di_q.size(), ei_q.size());
      end
   endtask

   task automatic test_partial_flush();
      int k;
      logic [63:0] wl;
      smp_re.delete(); smp_im.delete();
      for (int n = 0; n < 5; n++) begin
         smp_re.push_back(16'($urandom));
         smp_im.push_back(16'($urandom));
      end
      rd_set = '0; mode = 1'b0;
      clear_obs(); pulse_start(); stream(0); repeat (3) tick();
      pulse_stop();
      k = 0;
      while (busy && k < 10) begin tick(); k++; end
      repeat (4) tick();
      build_expect(1'b0, 1 << 30);
      n_checks++;
      if (k > 2 || busy !== 1'b0) begin
         n_fail++; $display("FAIL flush_busy: got %0d cycles busy=%b want <=2 busy=0", k, busy);
      end
      n_checks++;
      if (wa_q.size() != 3 || diff_writes() != -1) begin
         n_fail++; $display("FAIL flush_writes: got n=%0d want n=3 data per model", wa_q.size());
      end
      wl = (wd_q.size() > 0) ? wd_q[$] : 'x;
      n_checks++;
      if (wl[63:32] !== 32'd0) begin
         n_fail++; $display("FAIL flush_pad: got %h want 00000000", wl[63:32]);
      end
      n_checks++;
      if (di_q.size() != 1 || di_q[0] !== 6'd0 || dw_q[0] !== 7'd3) begin
         n_fail++;
         $display("FAIL flush_done: got n=%0d idx=%0d words=%0d want n=1 idx=0 words=3", di_q.size(), di_q[0], dw_q[0]);
      end
   endtask

   task automatic test_events();
      logic [15:0] r[5];
      logic [15:0] m[5];
      logic [63:0] w0, w1;
      rd_set = '0; mode = 1'b0;
      clear_obs(); pulse_stop(); tick();
      n_checks++;
      if (busy !== 1'b0 || wa_q.size() != 0) begin
         n_fail++; $display("FAIL stop_idle: got busy=%b writes=%0d want 0/0", busy, wa_q.size());
      end
      start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++; $display("FAIL start_stop_same: got busy=%b want 1", busy);
      end
      for (int i = 0; i < 5; i++) begin r[i] = 16'($urandom); m[i] = 16'($urandom); end
      smp_re.delete(); smp_im.delete();
      for (int i = 0; i < 3; i++) begin smp_re.push_back(r[i]); smp_im.push_back(m[i]); end
      stream(0); tick();
      pulse_start();
      smp_re.delete(); smp_im.delete();
      for (int i = 3; i < 5; i++) begin smp_re.push_back(r[i]); smp_im.push_back(m[i]); end
      stream(0); finish_run();
      w0 = (wd_q.size() > 0) ? wd_q[0] : 'x;
      w1 = (wd_q.size() > 1) ? wd_q[1] : 'x;
      n_checks++;
      if (wa_q.size() != 2 || w0 !== {m[1], r[1], m[0], r[0]} || w1 !== {m[4], r[4], m[3], r[3]}) begin
         n_fail++;
         $display("FAIL restart_writes: got n=%0d %h %h want n=2 %h %h", wa_q.size(), w0, w1,
                  {m[1], r[1], m[0], r[0]}, {m[4], r[4], m[3], r[3]});
      end
      n_checks++;
      if (wa_q.size() != 2 || wa_q[1] !== 12'd0) begin
         n_fail++; $display("FAIL restart_addr: got %h want 000", wa_q[1]);
      end
      n_checks++;
      if (di_q.size() != 1 || di_q[0] !== 6'd0 || dw_q[0] !== 7'd1) begin
         n_fail++;
         $display("FAIL restart_done: got n=%0d idx=%0d words=%0d want n=1 idx=0 words=1", di_q.size(), di_q[0], dw_q[0]);
      end
   endtask

   task automatic test_overflow();
      int d;
      smp_re.delete(); smp_im.delete();
      for (int n = 0; n < 64 * 64 * 2 + 18; n++) begin
         smp_re.push_back(16'($urandom));
         smp_im.push_back(16'($urandom));
      end
      rd_set = '0; mode = 1'b0;
      clear_obs(); pulse_start(); stream(0); repeat (6) tick();
      build_expect(1'b0, 4096);
      n_checks++;
      if (overflow !== 1'b1 || busy !== 1'b0) begin
         n_fail++; $display("FAIL ovf_flags: got ovf=%b busy=%b want 1/0", overflow, busy);
      end
      n_checks++;
      if (wa_q.size() != 4096) begin
         n_fail++; $display("FAIL ovf_wcount: got %0d want 4096", wa_q.size());
      end
      d = diff_writes(); n_checks++;
      if (d != -1) begin
         n_fail++;
         $display("FAIL ovf_data: word %0d got %h@%h want %h@%h", d, wd_q[d], wa_q[d], ed_q[d], ea_q[d]);
      end
      n_checks++;
      if (di_q.size() != 64 || diff_dones() != -1) begin
         n_fail++; $display("FAIL ovf_done: got n=%0d want n=64 idx 0..63", di_q.size());
      end
      pulse_start();
      n_checks++;
      if (overflow !== 1'b0 || busy !== 1'b1) begin
         n_fail++; $display("FAIL ovf_clear: got ovf=%b busy=%b want 0/1", overflow, busy);
      end
      pulse_stop(); repeat (4) tick();
      clear_obs();
   endtask

   task automatic test_wrap();
      int d;
      logic [11:0] a4095, a4096;
      smp_re.delete(); smp_im.delete();
      for (int n = 0; n < 3 * 4096 * 2; n++) begin
         smp_re.push_back(16'($urandom));
         smp_im.push_back(16'($urandom));
      end
      rd_set = '0; mode = 1'b0;
      clear_obs(); tick(); free_en = 1'b1;
      pulse_start(); stream(0); finish_run();
      free_en = 1'b0; fr_t.delete(); fr_v.delete();
      build_expect(1'b0, 1 << 30);
      n_checks++;
      if (overflow !== 1'b0 || wa_q.size() != 12288) begin
         n_fail++; $display("FAIL wrap_count: got ovf=%b n=%0d want 0/12288", overflow, wa_q.size());
      end
      d = diff_writes(); n_checks++;
      if (d != -1) begin
         n_fail++;
         $display("FAIL wrap_data: word %0d got %h@%h want %h@%h", d, wd_q[d], wa_q[d], ed_q[d], ea_q[d]);
      end
      a4095 = (wa_q.size() > 4096) ? wa_q[4095] : 'x;
      a4096 = (wa_q.size() > 4096) ? wa_q[4096] : 'x;
      n_checks++;
      if (a4095 !== 12'd4095 || a4096 !== 12'd0) begin
         n_fail++; $display("FAIL wrap_addr: got %0d->%0d want 4095->0", a4095, a4096);
      end
      d = diff_dones(); n_checks++;
      if (di_q.size() != 192 || d != -1) begin
         n_fail++; $display("FAIL wrap_done: got n=%0d first_bad=%0d want n=192 first_bad=-1", di_q.size(), d);
      end
   endtask

   task automatic test_reset_mid();
      rd_set = '0; mode = 1'b0;
      clear_obs(); pulse_start();
      for (int n = 0; n < 40; n++) begin
         in_valid = 1'b1; in_re = 16'($urandom); in_im = 16'($urandom);
         tick();
      end
      n_checks++;
      if (wren !== 1'b1 || busy !== 1'b1) begin
         n_fail++; $display("FAIL prereset_active: got wren=%b busy=%b want 1/1", wren, busy);
      end
      rst = 1'b0;
      #1;
      n_checks++;
      if ({waddr, wdata, wren, buffer_done, buffer_idx, buffer_words, busy, overflow} !== '0) begin
         n_fail++;
         $display("FAIL midreset_outputs: got waddr=%h wdata=%h wren=%b busy=%b want all 0", waddr, wdata, wren, busy);
      end
      tick(); tick();
      rst = 1'b1;
      tick();
      clear_obs();
      repeat (20) tick();
      in_valid = 1'b0;
      repeat (4) tick();
      n_checks++;
      if (wa_q.size() != 0 || di_q.size() != 0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL postreset_quiet: got writes=%0d dones=%0d busy=%b want 0/0/0", wa_q.size(), di_q.size(), busy);
      end
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; stop = 1'b0; mode = 1'b0;
      in_valid = 1'b0; in_re = '0; in_im = '0;
      repeat (3) tick();
      test_reset();
      rst = 1'b1;
      repeat (2) tick();
      test_16bit_ramp();
      test_16bit_random();
      test_8bit();
      test_partial_flush();
      test_events();
      test_overflow();
      test_wrap();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
